slave_rx_regfiles: RTL and testbench



---
 rtl/slave_rx_regfiles.sv | 131 +++++++++++++
 tb/tb_slave_rx_regfiles.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/slave_rx_regfiles.sv
// rtl/slave_rx_regfiles.sv - single-wire command receiver driving a 4 x 3-bit slave register file
// Optional even-parity bit in the frame: define SLAVE_RX_PARITY_EN.
module slave_rx_regfiles #(
    parameter int BIT_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [2:0] reg0,
    output logic [2:0] reg1,
    output logic [2:0] reg2,
    output logic [2:0] reg3,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rd_valid,
    output logic [2:0] rd_data
);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t           state;
    logic [1:0]       sync;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [5:0]       frame;
    logic             par_ok;
    logic [2:0]       regs [4];

    assign rxs  = sync[1];
    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];

    // Bits shift in MSB-first, so frame lands as {cmd, addr[1:0], data[2:0]}.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            par_ok   <= 1'b1;
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            sync     <= {sync[0], rx_line};
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    par_ok  <= 1'b1;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        frame   <= {frame[4:0], rxs};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd5) begin
`ifdef SLAVE_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SLAVE_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        par_ok <= (rxs == ^frame);
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (!rxs) begin
                            rx_err <= 1'b1;
                            state  <= WAIT_IDLE;
                        end else if (!par_ok) begin
                            rx_err <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            rx_done <= 1'b1;
                            if (frame[5]) begin
                                regs[frame[4:3]] <= frame[2:0];
                            end else begin
                                rd_data  <= regs[frame[4:3]];
                                rd_valid <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A stuck-low line must return high before a new start is seen.
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_rx_regfiles.sv
// tb/tb_slave_rx_regfiles.sv - directed plus random frame bench for slave_rx_regfiles
module tb_slave_rx_regfiles;
    localparam int BC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic [2:0] reg0, reg1, reg2, reg3;
    logic       rx_done, rx_err, rd_valid;
    logic [2:0] rd_data;

    slave_rx_regfiles #(.BIT_CYCLES(BC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rx_line(rx_line),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .rx_done(rx_done), .rx_err(rx_err), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Observed pulse activity
    int         n_done = 0, n_err = 0, n_rdv = 0, n_excl = 0;
    logic [2:0] last_rd = '0;
    logic [2:0] snap [4];

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) begin
                n_done++;
                snap[0] = reg0; snap[1] = reg1; snap[2] = reg2; snap[3] = reg3;
            end
            if (rx_err) n_err++;
            if (rd_valid) begin
                n_rdv++;
                last_rd = rd_data;
            end
            if ((rx_err && (rx_done || rd_valid)) || (rd_valid && !rx_done)) n_excl++;
        end
    end

    // Reference model: what the register file and pulse counts should be
    logic [2:0] mdl [4];
    logic [2:0] exp_rd = '0;
    int         exp_done = 0, exp_err = 0, exp_rdv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        tick(BC);
    endtask

    task automatic send_frame(input logic cmd, input logic [1:0] addr, input logic [2:0] data,
                              input logic stop_ok, input logic par_bad, input int idle_after);
        logic [5:0] f;
        f = {cmd, addr, data};
        send_bit(1'b0);
        for (int i = 5; i >= 0; i--) send_bit(f[i]);
`ifdef SLAVE_RX_PARITY_EN
        send_bit((^f) ^ par_bad);
`endif
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            rx_line = 1'b0;
            tick(20);
        end
        rx_line = 1'b1;
        tick(idle_after);
    endtask

    task automatic model(input logic cmd, input logic [1:0] addr, input logic [2:0] data,
                         input logic stop_ok, input logic par_bad);
        logic parity_fail;
`ifdef SLAVE_RX_PARITY_EN
        parity_fail = par_bad;
`else
        parity_fail = 1'b0;
`endif
        if (!stop_ok || parity_fail) begin
            exp_err++;
        end else begin
            exp_done++;
            if (cmd) begin
                mdl[addr] = data;
            end else begin
                exp_rd = mdl[addr];
                exp_rdv++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"}, n_done, exp_done);
        chk({tag, ".err"}, n_err, exp_err);
        chk({tag, ".rdv"}, n_rdv, exp_rdv);
        chk({tag, ".rd_data"}, {29'd0, rd_data}, {29'd0, exp_rd});
        chk({tag, ".reg0"}, {29'd0, reg0}, {29'd0, mdl[0]});
        chk({tag, ".reg1"}, {29'd0, reg1}, {29'd0, mdl[1]});
        chk({tag, ".reg2"}, {29'd0, reg2}, {29'd0, mdl[2]});
        chk({tag, ".reg3"}, {29'd0, reg3}, {29'd0, mdl[3]});
    endtask

    task automatic do_frame(input string tag, input logic cmd, input logic [1:0] addr,
                            input logic [2:0] data, input logic stop_ok, input logic par_bad);
        send_frame(cmd, addr, data, stop_ok, par_bad, 2 * BC);
        model(cmd, addr, data, stop_ok, par_bad);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mdl[i] = '0;
            snap[i] = '0;
        end
        tick(4);
        chk("rst.pulses", {29'd0, rx_done, rx_err, rd_valid}, 32'd0);
        rst = 1'b0;
        tick(3);
        check_all("reset");

        // Write then read back reg2; register must already hold the value while rx_done is high
        do_frame("wr2", 1'b1, 2'd2, 3'd5, 1'b1, 1'b0);
        chk("wr2.latency", {29'd0, snap[2]}, 32'd5);
        do_frame("rd2", 1'b0, 2'd2, 3'd0, 1'b1, 1'b0);
        chk("rd2.last_rd", {29'd0, last_rd}, 32'd5);

        // Glitch shorter than half a bit
        rx_line = 1'b0;
        tick(3);
        rx_line = 1'b1;
        tick(3 * BC);
        check_all("glitch");

        // Framing error, then a good write to the same address
        do_frame("ferr", 1'b1, 2'd1, 3'd7, 1'b0, 1'b0);
        do_frame("wr1", 1'b1, 2'd1, 3'd7, 1'b1, 1'b0);

        // Inverted parity: rejected with the feature, written without it
        do_frame("par", 1'b1, 2'd3, 3'd6, 1'b1, 1'b1);

        // Reset during the fourth data bit
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_line = 1'b1;
        tick(BC / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2 * BC);
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        exp_rd = '0;
        check_all("midrst");

        // Back-to-back writes with no idle gap
        send_frame(1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 0);
        send_frame(1'b1, 2'd1, 3'd4, 1'b1, 1'b0, 2 * BC);
        model(1'b1, 2'd0, 3'd3, 1'b1, 1'b0);
        model(1'b1, 2'd1, 3'd4, 1'b1, 1'b0);
        check_all("b2b");

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            logic       cmd;
            logic [1:0] addr;
            logic [2:0] data;
            logic       stop_ok, par_bad;
            cmd     = 1'($urandom_range(0, 1));
            addr    = 2'($urandom_range(0, 3));
            data    = 3'($urandom_range(0, 7));
            stop_ok = ($urandom_range(0, 7) != 0);
            par_bad = ($urandom_range(0, 7) == 0);
            do_frame($sformatf("rnd%0d", k), cmd, addr, data, stop_ok, par_bad);
        end

        chk("exclusive_pulses", n_excl, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
